axi4_rd_responder: RTL and testbench
====================================

AXI4_RD_RESPONDER -- requirements
Module: axi4_rd_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH_P, default 4, meaning the width of arid/rid.
REQ-002 SHALL have parameter ADDR_WIDTH_P, default 32, meaning the width of araddr.
REQ-003 SHALL have parameter DATA_WIDTH_P, default 32, meaning the rdata width; legal values are powers of two from 8 to 1024.
REQ-004 SHALL have parameter MEM_DEPTH_LOG2_P, default 8, meaning log2 of the number of DATA_WIDTH_P-bit memory words.
REQ-005 SHALL have one clock and a synchronous, active-low reset; the ports are clk (input, 1) and rst_n (input, 1).
REQ-006 SHALL have these AR channel ports: arid in ID_WIDTH_P; araddr in ADDR_WIDTH_P; arlen in 8; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
REQ-007 SHALL have these R channel ports: rid out ID_WIDTH_P; rdata out DATA_WIDTH_P; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
REQ-008 SHALL have a memory load port: mem_wr_en in 1; mem_wr_addr in MEM_DEPTH_LOG2_P (word index); mem_wr_data in DATA_WIDTH_P.

Function
REQ-009 SHALL implement an FSM with states IDLE and BURST, with one outstanding read and in-order operation.
REQ-010 SHALL drive arready=1 in IDLE and arready=0 in BURST.
REQ-011 SHALL, on an AR handshake in cycle N, capture id/addr/len/size/burst, enter BURST, and present the first beat with rvalid=1 in cycle N+1.
REQ-012 SHALL hold all R outputs stable while rvalid=1 and rready=0.
REQ-013 SHALL advance to the next beat on each R handshake; a beat counter runs 0..arlen, and rlast=1 exactly when counter==arlen.
REQ-014 SHALL, on the handshake of the beat with rlast=1, return to IDLE, set rvalid=0 in the next cycle, and set arready=1 in that same next cycle.
REQ-015 SHALL form the word index as addr[MEM_DEPTH_LOG2_P+B-1 : B], where B=log2(DATA_WIDTH_P/8).
REQ-016 SHALL compute the next address as follows: FIXED keeps addr unchanged; INCR adds DATA_WIDTH_P/8 to addr, modulo 2^ADDR_WIDTH_P with no 4 KB check.
REQ-017 SHALL register beat data, reading the memory array in the cycle the beat is fetched; a mem_wr_en to the same word in that cycle yields the old value (read-before-write).
REQ-018 SHALL allow mem_wr_en in any cycle, independent of FSM state.
REQ-019 SHALL drive rresp=SLVERR (2'b10) and rdata=0 on every beat of the burst when arsize != log2(DATA_WIDTH_P/8) or arburst=2'b11; addresses still advance as INCR.
REQ-020 SHALL drive rresp=DECERR (2'b11) and rdata=0 on any beat whose address bits above MEM_DEPTH_LOG2_P+B-1 are non-zero; other beats are OKAY.
REQ-021 SHALL drive rid equal to the captured arid on every beat of the burst.
REQ-022 SHALL, when arlen=0, produce a single beat with rlast=1.

Reset
REQ-023 SHALL, while rst_n=0 at a rising edge, force IDLE, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, arready=0, and clear the beat counter.
REQ-024 SHALL drive arready=1 in the first cycle after rst_n is sampled high.
REQ-025 SHALL, on reset asserted mid-burst, abort the burst with no further beats; memory contents are not reset.

Configuration
REQ-026 SHALL have macro AXI4_RD_RESPONDER_WRAP_EN which, when defined, supports WRAP (2'b10) bursts.
REQ-027 SHALL, for WRAP, treat arlen values 1, 3, 7 and 15 as legal: the wrap size is W=(arlen+1)*DATA_WIDTH_P/8, the next address is (addr & ~(W-1)) | ((addr+DATA_WIDTH_P/8) & (W-1)), and any other arlen gives SLVERR on all beats.
REQ-028 SHALL, when AXI4_RD_RESPONDER_WRAP_EN is undefined, answer WRAP bursts with SLVERR and rdata=0 on all arlen+1 beats, with addresses advancing as INCR and no wrap logic synthesized.

Verification (DATA_WIDTH_P=32, MEM_DEPTH_LOG2_P=8, arsize=2)
REQ-029 SHALL cover this scenario: mem[i]=i for all i; INCR araddr=0x10, arlen=3, arid=5 -> rdata 4,5,6,7; rid=5 on all beats; rlast on beat 4; rresp=0; rvalid one cycle after AR handshake.
REQ-030 SHALL cover this scenario: FIXED araddr=0x20, arlen=2 with rready toggling 1,0,1,0,1 -> three beats of rdata 8, each held stable while stalled.
REQ-031 SHALL cover this scenario: WRAP araddr=0x38, arlen=3 with the macro defined -> rdata 14,15,12,13 with OKAY; with the macro undefined -> 4 beats of SLVERR with rdata=0.
REQ-032 SHALL cover this scenario: INCR araddr=0x3FC, arlen=1 -> beat 1 rdata=255 OKAY; beat 2 (addr 0x400) DECERR with rdata=0.
REQ-033 SHALL cover this scenario: arsize=1, arlen=0 -> single beat with SLVERR and rlast=1; then, after mem_wr_en word 3=0xA5 and INCR read of 0xC, rdata=0xA5.
REQ-034 SHALL cover this scenario: reset asserted after beat 2 of an arlen=7 burst -> rvalid=0 in the next cycle; arready=1 in the first cycle after release; a new burst completes correctly.

Source files
------------

// File: rtl/axi4_rd_responder.sv
// axi4_rd_responder: single-outstanding, in-order AXI4 read responder backed by a loadable word memory.
// Define AXI4_RD_RESPONDER_WRAP_EN to support WRAP bursts; otherwise WRAP bursts answer SLVERR.
module axi4_rd_responder #(
    parameter int ID_WIDTH_P       = 4,
    parameter int ADDR_WIDTH_P     = 32,
    parameter int DATA_WIDTH_P     = 32,
    parameter int MEM_DEPTH_LOG2_P = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ID_WIDTH_P-1:0]       arid,
    input  logic [ADDR_WIDTH_P-1:0]     araddr,
    input  logic [7:0]                  arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [ID_WIDTH_P-1:0]       rid,
    output logic [DATA_WIDTH_P-1:0]     rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready,
    input  logic                        mem_wr_en,
    input  logic [MEM_DEPTH_LOG2_P-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH_P-1:0]     mem_wr_data
);
    localparam int B_LP  = $clog2(DATA_WIDTH_P / 8);
    localparam int HI_LP = MEM_DEPTH_LOG2_P + B_LP;
    localparam logic [ADDR_WIDTH_P-1:0] STEP_LP = ADDR_WIDTH_P'(DATA_WIDTH_P / 8);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [DATA_WIDTH_P-1:0]     r_mem [1 << MEM_DEPTH_LOG2_P];
    logic                        r_arready;
    logic                        r_rvalid;
    logic [ID_WIDTH_P-1:0]       r_id;
    logic [ADDR_WIDTH_P-1:0]     r_addr;
    logic [7:0]                  r_len;
    logic [7:0]                  r_cnt;
    logic [1:0]                  r_burst;
    logic                        r_err;
    logic [DATA_WIDTH_P-1:0]     r_rdata;
    logic [1:0]                  r_rresp;
    logic                        r_rlast;
`ifdef AXI4_RD_RESPONDER_WRAP_EN
    logic                        r_wrap;
    logic [ADDR_WIDTH_P-1:0]     w_wrap_mask;
`endif
    logic                        w_ar_hs;
    logic                        w_r_hs;
    logic                        w_done;
    logic                        w_wrap_bad;
    logic                        w_err_in;
    logic [ADDR_WIDTH_P-1:0]     w_incr_addr;
    logic [ADDR_WIDTH_P-1:0]     w_next_addr;
    logic                        w_fetch;
    logic [ADDR_WIDTH_P-1:0]     w_fetch_addr;
    logic                        w_fetch_err;
    logic                        w_fetch_dec;
    logic [7:0]                  w_fetch_cnt;
    logic [7:0]                  w_fetch_len;
    logic [MEM_DEPTH_LOG2_P-1:0] w_fetch_idx;

    // Handshakes, next state, request legality and the address of the beat to fetch next.
    always_comb begin
        w_ar_hs = arvalid && r_arready;
        w_r_hs  = r_rvalid && rready;
        w_done  = w_r_hs && r_rlast;
`ifdef AXI4_RD_RESPONDER_WRAP_EN
        w_wrap_bad  = !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15);
        w_wrap_mask = ((ADDR_WIDTH_P'(r_len) + ADDR_WIDTH_P'(1)) << B_LP) - ADDR_WIDTH_P'(1);
`else
        w_wrap_bad  = 1'b1;
`endif
        w_err_in    = arsize != 3'(B_LP) || arburst == 2'b11 || (arburst == 2'b10 && w_wrap_bad);
        w_incr_addr = r_addr + STEP_LP;
`ifdef AXI4_RD_RESPONDER_WRAP_EN
        w_next_addr = (r_burst == 2'b00 && !r_err) ? r_addr :
                      r_wrap ? ((r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask)) : w_incr_addr;
`else
        w_next_addr = (r_burst == 2'b00 && !r_err) ? r_addr : w_incr_addr;
`endif
        w_state_nxt  = (r_state == IDLE) ? (w_ar_hs ? BURST : IDLE) : (w_done ? IDLE : BURST);
        w_fetch      = w_ar_hs || (w_r_hs && !r_rlast);
        w_fetch_addr = (r_state == IDLE) ? araddr : w_next_addr;
        w_fetch_err  = (r_state == IDLE) ? w_err_in : r_err;
        w_fetch_cnt  = (r_state == IDLE) ? 8'd0 : r_cnt + 8'd1;
        w_fetch_len  = (r_state == IDLE) ? arlen : r_len;
        w_fetch_idx  = w_fetch_addr[HI_LP-1:B_LP];
        w_fetch_dec  = |(w_fetch_addr >> HI_LP);
    end

    // State register; arready/rvalid are registered from the next state so reset holds both low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_state_nxt == IDLE;
            r_rvalid  <= w_state_nxt == BURST;
        end
    end

    // Capture the request and register each beat when it is fetched; errored beats carry zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_rresp <= '0;
            r_rlast <= 1'b0;
`ifdef AXI4_RD_RESPONDER_WRAP_EN
            r_wrap  <= 1'b0;
`endif
        end else begin
            if (w_ar_hs) begin
                r_id    <= arid;
                r_len   <= arlen;
                r_burst <= arburst;
                r_err   <= w_err_in;
`ifdef AXI4_RD_RESPONDER_WRAP_EN
                r_wrap  <= arburst == 2'b10 && !w_err_in;
`endif
            end
            if (w_fetch) begin
                r_addr  <= w_fetch_addr;
                r_cnt   <= w_fetch_cnt;
                r_rlast <= w_fetch_cnt == w_fetch_len;
                r_rdata <= (w_fetch_err || w_fetch_dec) ? '0 : r_mem[w_fetch_idx];
                r_rresp <= w_fetch_err ? 2'b10 : (w_fetch_dec ? 2'b11 : 2'b00);
            end
        end
    end

    // Memory load port; contents survive reset and a same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (mem_wr_en) r_mem[mem_wr_addr] <= mem_wr_data;
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rid     = r_id;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;
endmodule

// File: tb/tb_axi4_rd_responder.sv
// tb_axi4_rd_responder: randomized and directed checks of axi4_rd_responder against a burst-level model.
module tb_axi4_rd_responder;
`ifdef AXI4_RD_RESPONDER_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;

    always #5 clk = ~clk;

    axi4_rd_responder dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    typedef struct packed {logic [3:0] id; logic [31:0] d; logic [1:0] r; logic l;} beat_t;
    beat_t log_q[$];

    int n_vec = 0;
    int n_err = 0;
    int ar_cnt = 0;
    int hs_cnt = 0;
    int rmode = 0;
    logic rand_mem = 1'b0;

    // Model state: whole-burst view (request, beat index) plus a shadow of the memory.
    logic [31:0] mm [256];
    logic        started = 1'b0;
    logic        m_busy = 1'b0, m_arready = 1'b0, m_valid = 1'b0, m_rst = 1'b0;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [3:0]  c_id;
    logic [31:0] c_addr;
    logic [7:0]  c_len;
    logic [1:0]  c_burst;
    logic        c_slv, c_wrap;
    int          c_beat;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Address of beat k computed directly from the burst rules.
    function automatic logic [31:0] beat_addr(int k);
        logic [31:0] w, base;
        if (c_burst == 2'b00 && !c_slv) return c_addr;
        if (!c_wrap) return c_addr + 32'(4 * k);
        w = 32'(4 * (int'(c_len) + 1));
        base = c_addr & ~(w - 32'd1);
        return base + ((c_addr - base + 32'(4 * k)) % w);
    endfunction

    task automatic load_beat();
        logic [31:0] a;
        logic dec;
        a = beat_addr(c_beat);
        dec = (a >> 10) != 0;
        m_rid   = c_id;
        m_rdata = (c_slv || dec) ? 32'd0 : mm[a[9:2]];
        m_rresp = c_slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
        m_rlast = c_beat == int'(c_len);
        m_valid = 1'b1;
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            m_busy = 0; m_arready = 0; m_valid = 0; m_rst = 1;
            m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
        end else begin
            m_rst = 0;
            if (m_valid && rready) begin
                hs_cnt++;
                if (m_rlast) begin
                    m_valid = 0; m_busy = 0; m_arready = 1;
                end else begin
                    c_beat++;
                    load_beat();
                end
            end else if (m_arready && arvalid) begin
                c_id = arid; c_addr = araddr; c_len = arlen; c_burst = arburst;
                c_slv = arsize != 3'd2 || arburst == 2'b11 ||
                        (arburst == 2'b10 && !(WRAP_EN && arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
                c_wrap = arburst == 2'b10 && !c_slv;
                c_beat = 0; m_busy = 1; m_arready = 0; ar_cnt++;
                load_beat();
            end else if (!m_busy) begin
                m_arready = 1;
            end
        end
        if (mem_wr_en) mm[mem_wr_addr] = mem_wr_data;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("arready", 64'(arready), 64'(m_arready));
            chk("rvalid", 64'(rvalid), 64'(m_valid));
            if (m_valid || m_rst) begin
                chk("rid", 64'(rid), 64'(m_rid));
                chk("rdata", 64'(rdata), 64'(m_rdata));
                chk("rresp", 64'(rresp), 64'(m_rresp));
                chk("rlast", 64'(rlast), 64'(m_rlast));
            end
            if (rvalid && rready && rst_n) log_q.push_back({rid, rdata, rresp, rlast});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rmode == 1) rready = !rready;
        else if (rmode == 2) rready = 1'($urandom_range(0, 1));
        if (rand_mem) begin
            mem_wr_en   = $urandom_range(0, 3) == 0;
            mem_wr_addr = 8'($urandom);
            mem_wr_data = $urandom;
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        int base;
        int t;
        base = ar_cnt;
        t = 0;
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
        while (ar_cnt == base && t < 400) begin
            step();
            t++;
        end
        arvalid = 1'b0;
        if (ar_cnt == base) begin
            n_vec++; n_err++;
            $display("FAIL ar_timeout: no AR handshake within %0d cycles", t);
        end else begin
            chk("rvalid_after_ar", 64'(rvalid), 64'(1));
            if (rmode == 1) rready = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_busy && t < 2000) begin
            step();
            t++;
        end
        if (m_busy) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: burst still open after %0d cycles", t);
        end
    endtask

    function automatic void pin(string nm, int i, logic [3:0] id, logic [31:0] d, logic [1:0] r, logic l);
        beat_t e;
        e = {id, d, r, l};
        if (i >= log_q.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: beat %0d missing, got %0d beats, expected %h", nm, i, log_q.size(), e);
        end else begin
            chk(nm, 64'(log_q[i]), 64'(e));
        end
    endfunction

    initial begin
        logic [31:0] a;
        int sel;
        int base;
        int t;
        logic [31:0] wexp [4];
        rst_n = 0; arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        rready = 1; mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0;
        repeat (3) step();
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        rst_n = 1;
        step();
        chk("arready_first", 64'(arready), 64'(1));
        for (int i = 0; i < 256; i++) begin
            mem_wr_en = 1; mem_wr_addr = 8'(i); mem_wr_data = 32'(i);
            step();
        end
        mem_wr_en = 0;
        step();

        log_q.delete();
        send_ar(4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
        wait_idle();
        chk("s1_count", 64'(log_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) pin("s1_beat", i, 4'd5, 32'(4 + i), 2'b00, i == 3);

        log_q.delete();
        rmode = 1;
        send_ar(4'd2, 32'h20, 8'd2, 3'd2, 2'b00);
        wait_idle();
        rmode = 0; rready = 1;
        chk("s2_count", 64'(log_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) pin("s2_beat", i, 4'd2, 32'd8, 2'b00, i == 2);

        log_q.delete();
        send_ar(4'd7, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_idle();
        wexp[0] = 14; wexp[1] = 15; wexp[2] = 12; wexp[3] = 13;
        chk("s3_count", 64'(log_q.size()), 64'(4));
`ifdef AXI4_RD_RESPONDER_WRAP_EN
        for (int i = 0; i < 4; i++) pin("s3_wrap", i, 4'd7, wexp[i], 2'b00, i == 3);
`else
        for (int i = 0; i < 4; i++) pin("s3_wrap_slverr", i, 4'd7, 32'd0, 2'b10, i == 3);
`endif

        log_q.delete();
        send_ar(4'd1, 32'h3FC, 8'd1, 3'd2, 2'b01);
        wait_idle();
        pin("s4_last_word", 0, 4'd1, 32'd255, 2'b00, 1'b0);
        pin("s4_decerr", 1, 4'd1, 32'd0, 2'b11, 1'b1);

        log_q.delete();
        send_ar(4'd3, 32'h0, 8'd0, 3'd1, 2'b01);
        wait_idle();
        pin("s5_size_slverr", 0, 4'd3, 32'd0, 2'b10, 1'b1);
        mem_wr_en = 1; mem_wr_addr = 8'd3; mem_wr_data = 32'hA5;
        step();
        mem_wr_en = 0;
        log_q.delete();
        send_ar(4'd3, 32'hC, 8'd0, 3'd2, 2'b01);
        wait_idle();
        pin("s5_loaded", 0, 4'd3, 32'hA5, 2'b00, 1'b1);

        log_q.delete();
        base = hs_cnt;
        send_ar(4'd9, 32'h0, 8'd7, 3'd2, 2'b01);
        t = 0;
        while (hs_cnt < base + 2 && t < 50) begin
            step();
            t++;
        end
        rst_n = 0;
        step();
        chk("s6_rvalid_rst", 64'(rvalid), 64'(0));
        chk("s6_arready_rst", 64'(arready), 64'(0));
        step();
        rst_n = 1;
        step();
        chk("s6_arready_release", 64'(arready), 64'(1));
        chk("s6_count", 64'(log_q.size()), 64'(2));
        pin("s6_beat0", 0, 4'd9, 32'd0, 2'b00, 1'b0);
        pin("s6_beat1", 1, 4'd9, 32'd1, 2'b00, 1'b0);
        log_q.delete();
        send_ar(4'd4, 32'h40, 8'd3, 3'd2, 2'b01);
        wait_idle();
        for (int i = 0; i < 4; i++) pin("s6_after", i, 4'd4, 32'(16 + i), 2'b00, i == 3);

        rmode = 2;
        rand_mem = 1;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            a = sel < 6 ? 32'($urandom_range(0, 1023)) :
                sel < 8 ? 32'($urandom_range(32'h3C0, 32'h43F)) :
                sel == 8 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            send_ar(4'($urandom), a, 8'($urandom_range(0, 15)),
                    $urandom_range(0, 7) == 0 ? 3'($urandom) : 3'd2, 2'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        rand_mem = 0; mem_wr_en = 0; rmode = 0; rready = 1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
